// File: rtl/wb_stage.sv
// rtl/wb_stage.sv - RV32I write-back stage: result select, load align/extend, registered regfile write, retire counter.
// Optional WB_BYPASS_EN adds a combinational write-to-read bypass on two read ports.
module wb_stage #(
  parameter int WORD_SIZE = 32,
  parameter int CNT_WIDTH = 32
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  logic                 i_flush,
  input  logic                 i_reg_write,
  input  logic [4:0]           i_rd,
  input  logic [1:0]           i_wb_sel,
  input  logic [WORD_SIZE-1:0] i_alu_result,
  input  logic [WORD_SIZE-1:0] i_pc_plus4,
  input  logic [WORD_SIZE-1:0] i_imm,
  input  logic [2:0]           i_funct3,
  input  logic [1:0]           i_addr_lo,
  input  logic [WORD_SIZE-1:0] i_mem_rdata,
  input  logic                 i_mem_rvalid,
`ifdef WB_BYPASS_EN
  input  logic [4:0]           i_Rnum1,
  input  logic [4:0]           i_Rnum2,
  input  logic [WORD_SIZE-1:0] i_Rd1,
  input  logic [WORD_SIZE-1:0] i_Rd2,
  output logic [WORD_SIZE-1:0] o_Rd1,
  output logic [WORD_SIZE-1:0] o_Rd2,
`endif
  output logic                 o_Wen,
  output logic [4:0]           o_Wnum,
  output logic [WORD_SIZE-1:0] o_Wd,
  output logic [CNT_WIDTH-1:0] o_retired
);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t state, next_state;

  logic       ld_reg_write;
  logic [4:0] ld_rd;
  logic [2:0] ld_funct3;
  logic [1:0] ld_addr_lo;

  logic                 commit;
  logic                 latch_load;
  logic                 c_reg_write;
  logic [4:0]           c_rd;
  logic [WORD_SIZE-1:0] c_data;
  logic [7:0]           ld_byte;
  logic [15:0]          ld_half;
  logic [WORD_SIZE-1:0] ld_data;

  assign o_ready = (state == S_IDLE);

  always_comb begin
    ld_byte = i_mem_rdata[7:0];
    case (ld_addr_lo)
      2'd0: ld_byte = i_mem_rdata[7:0];
      2'd1: ld_byte = i_mem_rdata[15:8];
      2'd2: ld_byte = i_mem_rdata[23:16];
      2'd3: ld_byte = i_mem_rdata[31:24];
      default: ld_byte = i_mem_rdata[7:0];
    endcase
    ld_half = ld_addr_lo[1] ? i_mem_rdata[31:16] : i_mem_rdata[15:0];
    case (ld_funct3)
      3'b000:  ld_data = {{(WORD_SIZE-8){ld_byte[7]}}, ld_byte};
      3'b001:  ld_data = {{(WORD_SIZE-16){ld_half[15]}}, ld_half};
      3'b100:  ld_data = {{(WORD_SIZE-8){1'b0}}, ld_byte};
      3'b101:  ld_data = {{(WORD_SIZE-16){1'b0}}, ld_half};
      default: ld_data = i_mem_rdata;
    endcase
  end

  always_comb begin
    next_state  = state;
    commit      = 1'b0;
    latch_load  = 1'b0;
    c_reg_write = i_reg_write;
    c_rd        = i_rd;
    c_data      = i_alu_result;
    case (state)
      S_IDLE: begin
        if (i_valid && !i_flush) begin
          if (i_wb_sel == 2'b01) begin
            latch_load = 1'b1;
            next_state = S_WAIT;
          end else begin
            commit = 1'b1;
            case (i_wb_sel)
              2'b10:   c_data = i_pc_plus4;
              2'b11:   c_data = i_imm;
              default: c_data = i_alu_result;
            endcase
          end
        end
      end
      S_WAIT: begin
        c_reg_write = ld_reg_write;
        c_rd        = ld_rd;
        c_data      = ld_data;
        // Flush wins over a same-cycle data return: the load is dropped.
        if (i_flush) begin
          next_state = S_IDLE;
        end else if (i_mem_rvalid) begin
          commit     = 1'b1;
          next_state = S_IDLE;
        end
      end
      default: next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state        <= S_IDLE;
      ld_reg_write <= 1'b0;
      ld_rd        <= 5'd0;
      ld_funct3    <= 3'd0;
      ld_addr_lo   <= 2'd0;
      o_Wen        <= 1'b0;
      o_Wnum       <= 5'd0;
      o_Wd         <= '0;
      o_retired    <= '0;
    end else begin
      state <= next_state;
      if (latch_load) begin
        ld_reg_write <= i_reg_write;
        ld_rd        <= i_rd;
        ld_funct3    <= i_funct3;
        ld_addr_lo   <= i_addr_lo;
      end
      o_Wen <= commit && c_reg_write && (c_rd != 5'd0);
      if (commit) begin
        o_Wnum    <= c_rd;
        o_Wd      <= c_data;
        o_retired <= o_retired + CNT_WIDTH'(1);
      end
    end
  end

`ifdef WB_BYPASS_EN
  assign o_Rd1 = (o_Wen && (o_Wnum == i_Rnum1) && (i_Rnum1 != 5'd0)) ? o_Wd : i_Rd1;
  assign o_Rd2 = (o_Wen && (o_Wnum == i_Rnum2) && (i_Rnum2 != 5'd0)) ? o_Wd : i_Rd2;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// tb/tb_wb_stage.sv - self-checking bench for wb_stage: vector table, corner sequences, randomized model comparison.
module tb_wb_stage;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        i_valid, i_flush, i_reg_write, i_mem_rvalid;
  logic [4:0]  i_rd;
  logic [1:0]  i_wb_sel, i_addr_lo;
  logic [2:0]  i_funct3;
  logic [31:0] i_alu_result, i_pc_plus4, i_imm, i_mem_rdata;
  logic        o_ready, o_Wen;
  logic [4:0]  o_Wnum;
  logic [31:0] o_Wd, o_retired;
  logic [4:0]  i_Rnum1, i_Rnum2;
  logic [31:0] i_Rd1, i_Rd2, o_Rd1, o_Rd2;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_ret;

  always #5 i_clk = ~i_clk;

  wb_stage #(.WORD_SIZE(32), .CNT_WIDTH(32)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .o_ready(o_ready),
    .i_flush(i_flush), .i_reg_write(i_reg_write), .i_rd(i_rd), .i_wb_sel(i_wb_sel),
    .i_alu_result(i_alu_result), .i_pc_plus4(i_pc_plus4), .i_imm(i_imm),
    .i_funct3(i_funct3), .i_addr_lo(i_addr_lo), .i_mem_rdata(i_mem_rdata),
    .i_mem_rvalid(i_mem_rvalid),
`ifdef WB_BYPASS_EN
    .i_Rnum1(i_Rnum1), .i_Rnum2(i_Rnum2), .i_Rd1(i_Rd1), .i_Rd2(i_Rd2),
    .o_Rd1(o_Rd1), .o_Rd2(o_Rd2),
`endif
    .o_Wen(o_Wen), .o_Wnum(o_Wnum), .o_Wd(o_Wd), .o_retired(o_retired)
  );

`ifndef WB_BYPASS_EN
  assign o_Rd1 = '0;
  assign o_Rd2 = '0;
`endif

  typedef struct {
    logic [1:0]  sel;
    logic [2:0]  f3;
    logic [1:0]  alo;
    logic [4:0]  rd;
    logic        rw;
    logic [31:0] alu;
    logic [31:0] pc4;
    logic [31:0] imm;
    logic [31:0] mem;
    int          delay;
    logic        exp_wen;
    logic [31:0] exp_wd;
  } vec_t;

  typedef struct {
    logic [4:0] rd;
    logic       rw;
    logic [2:0] f3;
    logic [1:0] alo;
  } pend_t;

  vec_t  vecs[11];
  pend_t pend[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic idle_inputs();
    i_valid = 0; i_flush = 0; i_reg_write = 0; i_rd = 0; i_wb_sel = 0;
    i_alu_result = 0; i_pc_plus4 = 0; i_imm = 0; i_funct3 = 0; i_addr_lo = 0;
    i_mem_rdata = 0; i_mem_rvalid = 0;
    i_Rnum1 = 0; i_Rnum2 = 0; i_Rd1 = 0; i_Rd2 = 0;
  endtask

  // Load result from the ISA rules, using shifts and signed arithmetic.
  function automatic logic [31:0] ld_ref(input logic [2:0] f3, input logic [1:0] alo, input logic [31:0] w);
    int unsigned b, h;
    b = (w >> (8 * alo)) & 32'hFF;
    h = (w >> (16 * alo[1])) & 32'hFFFF;
    case (f3)
      3'd0:    return (b >= 128) ? b - 256 : b;
      3'd1:    return (h >= 32768) ? h - 65536 : h;
      3'd4:    return b;
      3'd5:    return h;
      default: return w;
    endcase
  endfunction

  task automatic drive_instr(input logic [1:0] sel, input logic [4:0] rd, input logic rw,
                             input logic [31:0] alu, input logic [31:0] pc4, input logic [31:0] imm,
                             input logic [2:0] f3, input logic [1:0] alo);
    i_valid = 1; i_wb_sel = sel; i_rd = rd; i_reg_write = rw;
    i_alu_result = alu; i_pc_plus4 = pc4; i_imm = imm; i_funct3 = f3; i_addr_lo = alo;
  endtask

  task automatic apply_vec(input vec_t v);
    bit is_ld;
    is_ld = (v.sel == 2'b01);
    drive_instr(v.sel, v.rd, v.rw, v.alu, v.pc4, v.imm, v.f3, v.alo);
    i_flush = 0;
    i_mem_rvalid = is_ld;
    i_mem_rdata = 32'hFFFF_FFFF;
    tick();
    i_valid = 0; i_mem_rvalid = 0;
    if (is_ld) begin
      chk("ld_accept_ready", o_ready, 0);
      chk("ld_accept_wen", o_Wen, 0);
      chk("ld_accept_ret", o_retired, exp_ret);
      for (int k = 0; k < v.delay; k++) begin
        drive_instr(2'b00, 5'd31, 1'b1, 32'h5A5A_5A5A, 0, 0, 3'd0, 2'd0);
        tick();
        i_valid = 0;
        chk("ld_wait_wen", o_Wen, 0);
        chk("ld_wait_ready", o_ready, 0);
      end
      i_mem_rvalid = 1; i_mem_rdata = v.mem;
      tick();
      i_mem_rvalid = 0;
    end
    exp_ret++;
    chk("vec_wen", o_Wen, v.exp_wen);
    if (v.exp_wen) begin
      chk("vec_wnum", o_Wnum, v.rd);
      chk("vec_wd", o_Wd, v.exp_wd);
    end
    chk("vec_ret", o_retired, exp_ret);
    chk("vec_ready", o_ready, 1);
    tick();
    chk("vec_wen_drop", o_Wen, 0);
  endtask

  initial begin
    vecs[0]  = '{2'd0, 3'd0, 2'd0, 5'd5, 1'b1, 32'h0000_1234, 32'h0000_AAAA, 32'h0000_BBBB, 32'h0, 0, 1'b1, 32'h0000_1234};
    vecs[1]  = '{2'd2, 3'd0, 2'd0, 5'd1, 1'b1, 32'h0000_0011, 32'h0000_0104, 32'h0000_0022, 32'h0, 0, 1'b1, 32'h0000_0104};
    vecs[2]  = '{2'd3, 3'd0, 2'd0, 5'd2, 1'b1, 32'h0000_0033, 32'h0000_0044, 32'h1234_5000, 32'h0, 0, 1'b1, 32'h1234_5000};
    vecs[3]  = '{2'd1, 3'd0, 2'd2, 5'd7, 1'b1, 32'h0, 32'h0, 32'h0, 32'h0080_0000, 2, 1'b1, 32'hFFFF_FF80};
    vecs[4]  = '{2'd1, 3'd5, 2'd2, 5'd8, 1'b1, 32'h0, 32'h0, 32'h0, 32'h8001_0000, 0, 1'b1, 32'h0000_8001};
    vecs[5]  = '{2'd1, 3'd2, 2'd3, 5'd9, 1'b1, 32'h0, 32'h0, 32'h0, 32'hCAFE_F00D, 1, 1'b1, 32'hCAFE_F00D};
    vecs[6]  = '{2'd1, 3'd1, 2'd0, 5'd10, 1'b1, 32'h0, 32'h0, 32'h0, 32'h1234_8765, 0, 1'b1, 32'hFFFF_8765};
    vecs[7]  = '{2'd1, 3'd4, 2'd3, 5'd11, 1'b1, 32'h0, 32'h0, 32'h0, 32'h9A00_0000, 1, 1'b1, 32'h0000_009A};
    vecs[8]  = '{2'd1, 3'd6, 2'd1, 5'd12, 1'b1, 32'h0, 32'h0, 32'h0, 32'h0102_0304, 0, 1'b1, 32'h0102_0304};
    vecs[9]  = '{2'd0, 3'd0, 2'd0, 5'd0, 1'b1, 32'h0000_0055, 32'h0, 32'h0, 32'h0, 0, 1'b0, 32'h0};
    vecs[10] = '{2'd0, 3'd0, 2'd0, 5'd13, 1'b0, 32'h0000_0066, 32'h0, 32'h0, 32'h0, 0, 1'b0, 32'h0};

    idle_inputs();
    i_rst_n = 0;
    exp_ret = 0;
    #1;
    chk("rst_wen", o_Wen, 0);
    chk("rst_wnum", o_Wnum, 0);
    chk("rst_wd", o_Wd, 0);
    chk("rst_ret", o_retired, 0);
    tick(); tick();
    i_rst_n = 1;
    #1;
    chk("rst_ready", o_ready, 1);
    tick();

    foreach (vecs[i]) apply_vec(vecs[i]);

    // Back-to-back non-load commits, then flush must not cancel the asserted write.
    drive_instr(2'b00, 5'd4, 1'b1, 32'h1111_0001, 0, 0, 3'd0, 2'd0);
    tick();
    exp_ret++;
    chk("b2b_first_wen", o_Wen, 1);
    chk("b2b_first_wnum", o_Wnum, 4);
    drive_instr(2'b11, 5'd6, 1'b1, 0, 0, 32'h2222_0000, 3'd0, 2'd0);
    tick();
    exp_ret++;
    i_valid = 0;
    i_flush = 1;
    #1;
    chk("b2b_second_wen", o_Wen, 1);
    chk("b2b_second_wnum", o_Wnum, 6);
    chk("b2b_second_wd", o_Wd, 32'h2222_0000);
    chk("b2b_ret", o_retired, exp_ret);

    // Flush in IDLE blocks acceptance.
    drive_instr(2'b00, 5'd3, 1'b1, 32'h0BAD_0BAD, 0, 0, 3'd0, 2'd0);
    i_flush = 1;
    tick();
    i_valid = 0; i_flush = 0;
    chk("flush_idle_wen", o_Wen, 0);
    chk("flush_idle_ret", o_retired, exp_ret);
    chk("flush_idle_ready", o_ready, 1);

    // Flush in WAIT with a same-cycle data return drops the load.
    drive_instr(2'b01, 5'd14, 1'b1, 0, 0, 0, 3'd2, 2'd0);
    tick();
    i_valid = 0;
    i_flush = 1; i_mem_rvalid = 1; i_mem_rdata = 32'h7777_7777;
    tick();
    i_flush = 0; i_mem_rvalid = 0;
    chk("flush_wait_wen", o_Wen, 0);
    chk("flush_wait_ret", o_retired, exp_ret);
    chk("flush_wait_ready", o_ready, 1);
    tick();
    chk("flush_wait_late_wen", o_Wen, 0);

`ifdef WB_BYPASS_EN
    drive_instr(2'b00, 5'd3, 1'b1, 32'hDEAD_BEEF, 0, 0, 3'd0, 2'd0);
    tick();
    exp_ret++;
    i_valid = 0;
    i_Rnum1 = 5'd3; i_Rd1 = 32'h1; i_Rnum2 = 5'd0; i_Rd2 = 32'h0000_0022;
    #1;
    chk("byp_rd1", o_Rd1, 32'hDEAD_BEEF);
    chk("byp_rd2", o_Rd2, 32'h0000_0022);
    tick();
    #1;
    chk("byp_rd1_after", o_Rd1, 32'h1);
`endif

    // Reset while a load is pending.
    drive_instr(2'b01, 5'd15, 1'b1, 0, 0, 0, 3'd2, 2'd0);
    tick();
    i_valid = 0;
    chk("pre_rst_ready", o_ready, 0);
    #2;
    i_rst_n = 0;
    #1;
    chk("midwait_rst_wen", o_Wen, 0);
    chk("midwait_rst_ret", o_retired, 0);
    exp_ret = 0;
    tick();
    i_rst_n = 1;
    #1;
    chk("midwait_rst_ready", o_ready, 1);
    i_mem_rvalid = 1; i_mem_rdata = 32'h4444_4444;
    tick();
    i_mem_rvalid = 0;
    chk("idle_rvalid_wen", o_Wen, 0);
    chk("idle_rvalid_ret", o_retired, 0);

    // Randomized run against a queue-based model of the rules.
    for (int cyc = 0; cyc < 600; cyc++) begin
      bit          exp_commit, exp_wen;
      logic [4:0]  exp_rd;
      logic [31:0] exp_wd;
      pend_t       p;
      i_valid      = ($urandom_range(0, 9) < 6);
      i_flush      = ($urandom_range(0, 9) == 0);
      i_mem_rvalid = ($urandom_range(0, 9) < 4);
      i_mem_rdata  = $urandom;
      i_wb_sel     = 2'($urandom_range(0, 3));
      i_rd         = 5'($urandom_range(0, 7));
      i_reg_write  = ($urandom_range(0, 7) != 0);
      i_funct3     = 3'($urandom_range(0, 7));
      i_addr_lo    = 2'($urandom_range(0, 3));
      i_alu_result = $urandom;
      i_pc_plus4   = $urandom;
      i_imm        = $urandom;
      #1;
      chk("rnd_ready", o_ready, (pend.size() == 0));
      exp_commit = 0; exp_wen = 0; exp_rd = 0; exp_wd = 0;
      if (pend.size() == 0) begin
        if (i_valid && !i_flush) begin
          if (i_wb_sel == 2'b01) begin
            p.rd = i_rd; p.rw = i_reg_write; p.f3 = i_funct3; p.alo = i_addr_lo;
            pend.push_back(p);
          end else begin
            exp_commit = 1;
            exp_rd = i_rd;
            exp_wen = i_reg_write && (i_rd != 0);
            exp_wd = (i_wb_sel == 2'b00) ? i_alu_result : (i_wb_sel == 2'b10) ? i_pc_plus4 : i_imm;
          end
        end
      end else if (i_flush) begin
        void'(pend.pop_front());
      end else if (i_mem_rvalid) begin
        p = pend.pop_front();
        exp_commit = 1;
        exp_rd = p.rd;
        exp_wen = p.rw && (p.rd != 0);
        exp_wd = ld_ref(p.f3, p.alo, i_mem_rdata);
      end
      if (exp_commit) exp_ret++;
      tick();
      chk("rnd_wen", o_Wen, exp_wen);
      if (exp_wen) begin
        chk("rnd_wnum", o_Wnum, exp_rd);
        chk("rnd_wd", o_Wd, exp_wd);
      end
      chk("rnd_ret", o_retired, exp_ret);
`ifdef WB_BYPASS_EN
      i_Rnum1 = 5'($urandom_range(0, 7)); i_Rd1 = $urandom;
      i_Rnum2 = 5'($urandom_range(0, 7)); i_Rd2 = $urandom;
      #1;
      chk("rnd_rd1", o_Rd1, (exp_wen && exp_rd == i_Rnum1 && i_Rnum1 != 0) ? exp_wd : i_Rd1);
      chk("rnd_rd2", o_Rd2, (exp_wen && exp_rd == i_Rnum2 && i_Rnum2 != 0) ? exp_wd : i_Rd2);
`endif
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
